// File: rtl/img_sub_pkg.sv
// Shared sizes and enumerations for the image subtract engine.
package img_sub_pkg;
    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 8;
    localparam int NUM_PIXELS = 81920;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
    typedef enum logic {MODE_SAT = 1'b0, MODE_ABS = 1'b1} mode_e;
endpackage

// File: rtl/pixel_diff_unit.sv
// One-stage pixel difference: saturating or absolute a-b, plus a strict
// threshold compare. Outputs are registered alongside a valid bit.
module pixel_diff_unit #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] thr_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] res_o,
    output logic              over_o
);
    import img_sub_pkg::*;

    logic [DATA_W:0]   diff;
    logic [DATA_W:0]   neg;
    logic [DATA_W-1:0] res_d;
    logic              vld_q, over_q;
    logic [DATA_W-1:0] res_q;

    // 9-bit diff; the sign bit picks between a-b and either 0 or b-a
    always_comb begin
        diff  = {1'b0, a_i} - {1'b0, b_i};
        neg   = {1'b0, b_i} - {1'b0, a_i};
        res_d = '0;
        if (!diff[DATA_W])
            res_d = diff[DATA_W-1:0];
        else if (mode_e'(mode_i) == MODE_ABS)
            res_d = neg[DATA_W-1:0];
    end

    // Register the result; data only moves when a pixel is retiring
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= 1'b0;
            res_q  <= '0;
            over_q <= 1'b0;
        end else begin
            vld_q <= vld_i;
            if (vld_i) begin
                res_q  <= res_d;
                over_q <= (res_d > thr_i);
            end
        end
    end

    assign vld_o  = vld_q;
    assign res_o  = res_q;
    assign over_o = over_q;
endmodule

// File: rtl/image_subtract_engine.sv
// Streams two images through pixel_diff_unit into the result memory at one
// pixel per clock and counts pixels whose difference exceeds a threshold.
module image_subtract_engine #(
    parameter int ADDR_W     = img_sub_pkg::ADDR_W,
    parameter int DATA_W     = img_sub_pkg::DATA_W,
    parameter int NUM_PIXELS = img_sub_pkg::NUM_PIXELS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] threshold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] over_count,
    output logic [ADDR_W-1:0] img1_address,
    output logic              img1_clken,
    input  logic [DATA_W-1:0] img1_readdata,
    output logic [ADDR_W-1:0] img2_address,
    output logic              img2_clken,
    input  logic [DATA_W-1:0] img2_readdata,
    output logic [ADDR_W-1:0] res_address,
    output logic              res_chipselect,
    output logic              res_write,
    output logic [DATA_W-1:0] res_writedata
);
    import img_sub_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              drain_q, drain_d;
    logic [ADDR_W-1:0] addr_d1_q, addr_d2_q;
    logic              rd_vld_q;
    logic              mode_q;
    logic [DATA_W-1:0] thr_q;
    logic [ADDR_W-1:0] over_cnt_q;
    logic              px_vld, px_over;
    logic [DATA_W-1:0] px_res;
    logic              accept;

    assign accept = (state_q == IDLE) && start;

    // State, address counter and drain counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    // Next state: one address per RUN cycle, two DRAIN cycles, one DONE cycle
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                addr_d  = '0;
            end
            RUN: if (addr_q == LAST_ADDR) begin
                state_d = DRAIN;
                drain_d = 1'b0;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read-valid and address delay line, aligned with memory and diff latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_q  <= 1'b0;
            addr_d1_q <= '0;
            addr_d2_q <= '0;
        end else begin
            rd_vld_q  <= (state_q == RUN);
            addr_d1_q <= addr_q;
            addr_d2_q <= addr_d1_q;
        end
    end

    // Run parameters latch at start; over_count clears there and then counts retirements
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= 1'b0;
            thr_q      <= '0;
            over_cnt_q <= '0;
        end else if (accept) begin
            mode_q     <= mode;
            thr_q      <= threshold;
            over_cnt_q <= '0;
        end else if (px_vld && px_over) begin
            over_cnt_q <= over_cnt_q + ADDR_W'(1);
        end
    end

    pixel_diff_unit #(.DATA_W(DATA_W)) u_diff (
        .clk    (clk),
        .reset  (reset),
        .vld_i  (rd_vld_q),
        .a_i    (img1_readdata),
        .b_i    (img2_readdata),
        .mode_i (mode_q),
        .thr_i  (thr_q),
        .vld_o  (px_vld),
        .res_o  (px_res),
        .over_o (px_over)
    );

    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign over_count     = over_cnt_q;
    assign img1_address   = addr_q;
    assign img2_address   = addr_q;
    // Read ports stay enabled one cycle past RUN so the last read completes
    assign img1_clken     = (state_q == RUN) || rd_vld_q;
    assign img2_clken     = (state_q == RUN) || rd_vld_q;
    assign res_address    = addr_d2_q;
    assign res_write      = px_vld;
    assign res_chipselect = px_vld;
    assign res_writedata  = px_res;
endmodule

// File: doc/image_subtract_engine.md
# image_subtract_engine

Streams two 320×256 8-bit images out of the on-chip image memories (imagem1, imagem2) and writes their per-pixel difference into the result image memory. It also counts pixels whose difference exceeds a threshold. It sits directly downstream of the image memories and is started by the Nios control path. Throughput is one pixel per clock, with no stalls.

## Interface
Parameters:
- ADDR_W, 17, memory word-address width
- DATA_W, 8, pixel width
- NUM_PIXELS, 81920, pixels per image (320×256)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0 = saturating subtract, 1 = absolute difference; latched at start
- threshold  in  8  count threshold; latched at start
- busy  out  1  high from first address cycle through last write
- done  out  1  one-cycle pulse after last write
- over_count  out  ADDR_W  pixels with diff > threshold; valid when done, held until next start
- img1_address  out  ADDR_W  read address to image-1 memory
- img1_clken  out  1  clock enable to image-1 memory
- img1_readdata  in  DATA_W  image-1 pixel
- img2_address  out  ADDR_W  read address to image-2 memory (always equal to img1_address)
- img2_clken  out  1  clock enable to image-2 memory
- img2_readdata  in  DATA_W  image-2 pixel
- res_address  out  ADDR_W  result write address
- res_chipselect  out  1  result memory select
- res_write  out  1  result write strobe
- res_writedata  out  DATA_W  difference pixel

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on start=1. On the same edge: latch mode and threshold, clear over_count, load address 0.
  - RUN: issue one address per cycle, 0 to NUM_PIXELS-1. After NUM_PIXELS-1 is issued, go to DRAIN.
  - DRAIN: 2 cycles, letting the pipeline retire the last two pixels; then go to DONE.
  - DONE: 1 cycle with done=1; then go to IDLE.
- start outside IDLE is ignored; no queuing.
- Arithmetic: form a 9-bit signed diff a−b, where a = img1, b = img2.
  - mode 0: result = (a ≥ b) ? a−b : 0.
  - mode 1: result = |a−b|, range 0..255; no overflow is possible.
- over_count increments on each retired pixel with result > threshold (strict). Maximum value is 81920, which fits in 17 bits, so no wrap.
- img*_clken is high only in RUN and for the one following cycle, so the memories' read ports idle otherwise.
- res_chipselect equals res_write.
- Reset values (also on reset mid-operation): state IDLE, busy/done/res_write/res_chipselect/img*_clken = 0, all addresses 0, res_writedata 0, over_count 0. An in-flight pixel is discarded and no partial write occurs after reset deasserts.

## Timing
- Memory read latency is 1 cycle: the address is captured by the memory at an edge, and readdata is sampled at the next edge.
- Cycle 0: start=1 in IDLE.
- Cycle k, for k = 1..NUM_PIXELS: img*_address = k−1, busy=1.
- Cycle k+1: readdata for address k−1 is valid; the diff is computed combinationally and registered.
- Cycle k+2: res_write=1, res_address=k−1, res_writedata=result. Pipeline latency from address to write is 2 cycles.
- The last write occurs in cycle NUM_PIXELS+2.
- Cycle NUM_PIXELS+3: done=1, busy=0, over_count final.
- Total run time is NUM_PIXELS+3 cycles from the start cycle.
- A new start is accepted in cycle NUM_PIXELS+4 at the earliest.

## Structure
- Package img_sub_pkg holds:
  - ADDR_W, DATA_W, NUM_PIXELS
  - state enum {IDLE, RUN, DRAIN, DONE}
  - mode enum {MODE_SAT = 0, MODE_ABS = 1}
- Sub-module pixel_diff_unit: a, b, mode, threshold in; registered result and over flag out, plus a valid pipeline bit.
- The top level holds the FSM, address counter, address delay line (2 stages), and over_count.

## Test plan
- Reset: assert reset mid-RUN at address 100 → next cycle all outputs 0, state IDLE; no res_write after deassert; a later start runs a full image correctly.
- Saturating mode: img1 = 0x50, img2 = 0x80 at addr 7; mode 0 → res_writedata 0x00 at res_address 7, two cycles after img*_address=7.
- Absolute mode: same data with mode 1 → 0x30. Also img1 = 0xFF, img2 = 0x00 → 0xFF.
- Threshold: images with 1000 pixels of diff 11 and the rest diff 10, threshold=10 → over_count = 1000 at done. With threshold=9 → 81920.
- Full-run timing: start in cycle 0 → first res_write in cycle 3, last res_write at address 81919 in cycle 81922, done pulse in cycle 81923 lasting exactly 1 cycle, exactly 81920 writes total.
- Start while busy: pulse start at cycle 500 → ignored. Mode and threshold changes after the start cycle have no effect; the run ends at the same cycle as without the pulse.
